// File: rtl/affine_iterator_if.sv
// affine_iterator_if: job/result handshake bundle for the affine iterator
interface affine_iterator_if #(
    parameter int DIM    = 3,
    parameter int WIDTH  = 32,
    parameter int ITER_W = 8
);
    logic                       s_valid;
    logic                       s_ready;
    logic [DIM*DIM*WIDTH-1:0]   A;
    logic [DIM*WIDTH-1:0]       x_in;
    logic [DIM*WIDTH-1:0]       U;
    logic [ITER_W-1:0]          iter;
    logic                       m_valid;
    logic                       m_ready;
    logic [DIM*WIDTH-1:0]       x_out;
    logic                       busy;

    modport slave  (input  s_valid, A, x_in, U, iter, m_ready,
                    output s_ready, m_valid, x_out, busy);
    modport master (output s_valid, A, x_in, U, iter, m_ready,
                    input  s_ready, m_valid, x_out, busy);
endinterface

// File: rtl/affine_iterator.sv
// affine_iterator: iterates x <= A*x + U in signed fixed point with one shared multiplier
module affine_iterator #(
    parameter int DIM    = 3,
    parameter int WIDTH  = 32,
    parameter int FRAC   = 24,
    parameter int ITER_W = 8,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    affine_iterator_if.slave  bus
);
    localparam int ACC_W = 2*WIDTH + $clog2(DIM+1);
    localparam int IDX_W = $clog2(DIM);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC-1);
    localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (WIDTH-1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM-1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, STORE, OUT} state_t;

    state_t                   state;
    logic                     s_ready, m_valid, busy;
    logic [DIM*WIDTH-1:0]     x_out;
    logic signed [WIDTH-1:0]  a_r [DIM][DIM];
    logic signed [WIDTH-1:0]  x_cur [DIM];
    logic signed [WIDTH-1:0]  x_nxt [DIM];
    logic signed [WIDTH-1:0]  u_r [DIM];
    logic signed [WIDTH-1:0]  nvec [DIM];
    logic [DIM*WIDTH-1:0]     cur_flat, nvec_flat;
    logic [ITER_W-1:0]        iter_r, k;
    logic [IDX_W-1:0]         row, col, nrow;
    logic signed [ACC_W-1:0]  acc, rnd;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]  res;
    logic                     accept, last_row, last_iter;

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.busy    = busy;
    assign bus.x_out   = x_out;

    // Offset preload: U[i] aligned to the product's binary point
    function automatic logic signed [ACC_W-1:0] pre(input logic signed [WIDTH-1:0] v);
        return ACC_W'(v) <<< FRAC;
    endfunction

    assign accept    = state == IDLE && bus.s_valid && s_ready;
    assign last_row  = row == LAST;
    assign last_iter = k == iter_r - ITER_W'(1);
    assign nrow      = last_row ? '0 : row + IDX_W'(1);
    assign prod      = a_r[row][col] * x_cur[col];
    assign rnd       = (acc + HALF) >>> FRAC;
    assign res       = WRAP != 0  ? rnd[WIDTH-1:0] :
                       rnd > MAXV ? MAXV[WIDTH-1:0] :
                       rnd < MINV ? MINV[WIDTH-1:0] : rnd[WIDTH-1:0];

    // Next-iteration vector with the row being stored patched in, plus flat views
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            nvec[i] = IDX_W'(i) == row ? res : x_nxt[i];
            cur_flat[i*WIDTH +: WIDTH]  = x_cur[i];
            nvec_flat[i*WIDTH +: WIDTH] = nvec[i];
        end
    end

    // Job operands and the double-buffered state vector (no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            iter_r <= bus.iter;
            for (int i = 0; i < DIM; i++) begin
                x_cur[i] <= bus.x_in[i*WIDTH +: WIDTH];
                u_r[i]   <= bus.U[i*WIDTH +: WIDTH];
                for (int j = 0; j < DIM; j++)
                    a_r[i][j] <= bus.A[(i*DIM+j)*WIDTH +: WIDTH];
            end
        end else if (state == STORE) begin
            x_nxt[row] <= res;
            if (last_row)
                for (int i = 0; i < DIM; i++)
                    x_cur[i] <= nvec[i];
        end
    end

    // Control FSM with registered handshake outputs, accumulator and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
            x_out   <= '0;
            acc     <= '0;
            k       <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_ready <= !accept;
                    if (accept) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    row <= '0;
                    col <= '0;
                    k   <= '0;
                    acc <= pre(u_r[0]);
                    if (iter_r == '0) begin
                        state   <= OUT;
                        m_valid <= 1'b1;
                        x_out   <= cur_flat;
                    end else begin
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    col <= col == LAST ? '0 : col + IDX_W'(1);
                    if (col == LAST)
                        state <= STORE;
                end
                STORE: begin
                    row <= nrow;
                    acc <= pre(u_r[nrow]);
                    if (last_row)
                        k <= k + ITER_W'(1);
                    if (last_row && last_iter) begin
                        state   <= OUT;
                        m_valid <= 1'b1;
                        x_out   <= nvec_flat;
                    end else begin
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        s_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_affine_iterator.sv
// tb_affine_iterator: directed vector table plus handshake/reset sequences, saturating and wrapping instances side by side
module tb_affine_iterator;
    localparam int DIM = 3;
    localparam int W   = 32;
    localparam int IW  = 8;
    localparam logic [W-1:0] ONE = 32'h01000000;

    typedef struct {
        string                    name;
        logic [DIM*DIM*W-1:0]     a;
        logic [DIM*W-1:0]         x;
        logic [DIM*W-1:0]         u;
        logic [IW-1:0]            it;
        logic [DIM*W-1:0]         es;
        logic [DIM*W-1:0]         ew;
        int                       lat;
        int                       tol;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t tv [8];

    always #5 clk = ~clk;

    affine_iterator_if #(.DIM(DIM), .WIDTH(W), .ITER_W(IW)) bs ();
    affine_iterator_if #(.DIM(DIM), .WIDTH(W), .ITER_W(IW)) bw ();

    assign bw.s_valid = bs.s_valid;
    assign bw.A       = bs.A;
    assign bw.x_in    = bs.x_in;
    assign bw.U       = bs.U;
    assign bw.iter    = bs.iter;
    assign bw.m_ready = bs.m_ready;

    affine_iterator #(.DIM(DIM), .WIDTH(W), .FRAC(24), .ITER_W(IW), .WRAP(0))
        dut_sat (.clk(clk), .reset_n(reset_n), .bus(bs.slave));
    affine_iterator #(.DIM(DIM), .WIDTH(W), .FRAC(24), .ITER_W(IW), .WRAP(1))
        dut_wrap (.clk(clk), .reset_n(reset_n), .bus(bw.slave));

    function automatic logic [DIM*W-1:0] v3(input logic [W-1:0] a, b, c);
        return {c, b, a};
    endfunction

    function automatic logic [DIM*DIM*W-1:0] mat(input logic [DIM*W-1:0] r0, r1, r2);
        return {r2, r1, r0};
    endfunction

    function automatic logic [DIM*DIM*W-1:0] diag(input logic [W-1:0] d);
        return mat(v3(d, 0, 0), v3(0, d, 0), v3(0, 0, d));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp, input int tol);
        int d;
        checks++;
        d = $signed(act) - $signed(exp);
        if ($isunknown(act) || d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (+/-%0d)", nm, act, exp, tol);
        end
    endtask

    task automatic start(input vec_t v);
        int n = 0;
        @(negedge clk);
        bs.A = v.a; bs.x_in = v.x; bs.U = v.u; bs.iter = v.it; bs.s_valid = 1'b1;
        while (!bs.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bs.s_ready) chk({v.name, " s_ready wait"}, 64'(bs.s_ready), 64'd1);
        @(posedge clk);
        #1;
        bs.s_valid = 1'b0;
        bs.A = ~v.a; bs.x_in = ~v.x; bs.U = ~v.u; bs.iter = ~v.it;
    endtask

    task automatic wait_mv(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bs.m_valid && lat < 200);
    endtask

    task automatic handshake(input string nm);
        @(negedge clk);
        bs.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bs.m_ready = 1'b0;
        chk({nm, " m_valid after hs"}, 64'(bs.m_valid), 64'd0);
        chk({nm, " s_ready after hs"}, 64'(bs.s_ready), 64'd1);
    endtask

    task automatic check_result(input vec_t v);
        for (int i = 0; i < DIM; i++) begin
            chk_tol($sformatf("%s sat x[%0d]", v.name, i), bs.x_out[i*W +: W], v.es[i*W +: W], v.tol);
            chk_tol($sformatf("%s wrap x[%0d]", v.name, i), bw.x_out[i*W +: W], v.ew[i*W +: W], v.tol);
        end
    endtask

    initial begin
        int lat;
        logic [DIM*W-1:0] held;
        bs.s_valid = 1'b0; bs.m_ready = 1'b0; bs.iter = '0;
        bs.A = '0; bs.x_in = '0; bs.U = '0;

        tv[0] = '{"ident", diag(ONE), v3(ONE, 2*ONE, 3*ONE), '0, 8'd1,
                  v3(ONE, 2*ONE, 3*ONE), v3(ONE, 2*ONE, 3*ONE), 13, 0};
        tv[1] = '{"mix", mat(v3(0, 32'h00800000, 32'h000CCCCD),
                             v3(32'h00555555, 0, 32'h00555555),
                             v3(32'h000CCCCD, 32'h00800000, 0)),
                  v3(ONE, 2*ONE, 3*ONE), v3(32'h0019999A, 32'h00333333, 32'h004CCCCD), 8'd1,
                  v3(32'h01400000, 32'h01888889, 32'h0159999A),
                  v3(32'h01400000, 32'h01888889, 32'h0159999A), 13, 2};
        tv[2] = '{"half2", diag(32'h00800000), v3(ONE, 2*ONE, 3*ONE), '0, 8'd2,
                  v3(32'h00400000, 32'h00800000, 32'h00C00000),
                  v3(32'h00400000, 32'h00800000, 32'h00C00000), 25, 0};
        tv[3] = '{"iter0", diag(32'h00800000), v3(ONE, 2*ONE, 3*ONE), '0, 8'd0,
                  v3(ONE, 2*ONE, 3*ONE), v3(ONE, 2*ONE, 3*ONE), 1, 0};
        tv[4] = '{"satpos", diag(32'h40000000), v3(4*ONE, 4*ONE, 4*ONE), '0, 8'd1,
                  v3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF), '0, 13, 0};
        tv[5] = '{"satneg", diag(32'h40000000), v3(32'hFC000000, 32'hFC000000, 32'hFC000000), '0, 8'd1,
                  v3(32'h80000000, 32'h80000000, 32'h80000000), '0, 13, 0};
        tv[6] = '{"round", diag(32'h00800000), v3(32'd3, 32'hFFFFFFFD, 32'd1), '0, 8'd1,
                  v3(32'd2, 32'hFFFFFFFF, 32'd1), v3(32'd2, 32'hFFFFFFFF, 32'd1), 13, 0};
        tv[7] = '{"offset3", '0, v3(5*ONE, 6*ONE, 7*ONE), v3(ONE, 32'hFF000000, 32'h00800000), 8'd3,
                  v3(ONE, 32'hFF000000, 32'h00800000), v3(ONE, 32'hFF000000, 32'h00800000), 37, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset m_valid", 64'(bs.m_valid), 64'd0);
        chk("reset busy", 64'(bs.busy), 64'd0);
        chk("reset x_out", 64'(bs.x_out), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready after reset", 64'(bs.s_ready), 64'd1);

        for (int t = 0; t < 8; t++) begin
            start(tv[t]);
            wait_mv(lat);
            chk({tv[t].name, " latency"}, 64'(lat), 64'(tv[t].lat));
            chk({tv[t].name, " wrap m_valid"}, 64'(bw.m_valid), 64'd1);
            check_result(tv[t]);
            handshake(tv[t].name);
        end

        start(tv[2]);
        repeat (5) @(posedge clk);
        #1;
        bs.s_valid = 1'b1; bs.A = diag(ONE); bs.iter = 8'd1;
        chk("hold s_ready busy", 64'(bs.s_ready), 64'd0);
        chk("hold busy", 64'(bs.busy), 64'd1);
        @(posedge clk);
        #1;
        bs.s_valid = 1'b0;
        wait_mv(lat);
        chk("hold latency", 64'(lat), 64'd19);
        chk("hold result", 64'(bs.x_out), 64'(tv[2].es));
        held = bs.x_out;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("hold m_valid", 64'(bs.m_valid), 64'd1);
            chk("hold x_out", 64'(bs.x_out), 64'(held));
            chk("hold s_ready", 64'(bs.s_ready), 64'd0);
        end
        handshake("hold");
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            chk("no phantom job", 64'(bs.m_valid), 64'd0);
        end
        chk("x_out kept", 64'(bs.x_out), 64'(held));

        start(tv[0]);
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset m_valid", 64'(bs.m_valid), 64'd0);
        chk("midreset busy", 64'(bs.busy), 64'd0);
        chk("midreset x_out", 64'(bs.x_out), 64'd0);
        chk("midreset wrap busy", 64'(bw.busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready after midreset", 64'(bs.s_ready), 64'd1);
        start(tv[1]);
        wait_mv(lat);
        chk("post-reset latency", 64'(lat), 64'd13);
        check_result(tv[1]);
        handshake("post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/affine_iterator.md
AFFINE_ITERATOR -- requirements
Module: affine_iterator

Interface
REQ-001 SHALL have parameter DIM, default 3, meaning vector dimension (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, meaning signed fixed-point word width.
REQ-003 SHALL have parameter FRAC, default 24, meaning fractional bits (1..WIDTH-2).
REQ-004 SHALL have parameter ITER_W, default 8, meaning iteration-count width.
REQ-005 SHALL have parameter WRAP, default 0, meaning overflow mode: 0 = saturate, 1 = modular wrap.
REQ-006 SHALL provide port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-007 SHALL provide port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL provide port s_valid, input, 1, meaning the job inputs are valid.
REQ-009 SHALL provide port s_ready, output, 1, meaning the block can accept a job.
REQ-010 SHALL provide port A, input, DIM*DIM*WIDTH, meaning the matrix, row-major; A[i][j] at bits (i*DIM+j)*WIDTH.
REQ-011 SHALL provide port x_in, input, DIM*WIDTH, meaning the initial state vector; element i at bits i*WIDTH.
REQ-012 SHALL provide port U, input, DIM*WIDTH, meaning the offset vector.
REQ-013 SHALL provide port iter, input, ITER_W, meaning the number of map iterations.
REQ-014 SHALL provide port m_valid, output, 1, meaning the result is valid.
REQ-015 SHALL provide port m_ready, input, 1, meaning the consumer accepts the result.
REQ-016 SHALL provide port x_out, output, DIM*WIDTH, meaning the result vector.
REQ-017 SHALL provide port busy, output, 1, meaning a job is in progress (state not IDLE).

Function
REQ-018 SHALL compute x(k+1) = A*x(k) + U, repeated iter times from x(0)=x_in, in signed Q(WIDTH-FRAC).FRAC.
REQ-019 SHALL accept a job on a cycle with s_valid && s_ready, registering A, x_in, U and iter in that cycle.
REQ-020 SHALL implement FSM IDLE -> LOAD -> MAC -> STORE -> (MAC | OUT) -> IDLE.
REQ-021 SHALL assert s_ready only in IDLE.
REQ-022 SHALL use one signed WIDTH x WIDTH multiplier, adding one product per MAC cycle.
REQ-023 SHALL, per row i, preload the accumulator with U[i]<<FRAC, run DIM MAC cycles (j = 0..DIM-1), then one STORE cycle.
REQ-024 SHALL size the accumulator at 2*WIDTH+clog2(DIM+1) bits so no internal overflow occurs.
REQ-025 SHALL have STORE compute (acc + 2^(FRAC-1)) >>> FRAC (round-half-up).
REQ-026 SHALL, when WRAP=0, saturate the STORE result to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 SHALL, when WRAP=1, keep the low WIDTH bits of the STORE result.
REQ-028 SHALL read only x(k) during iteration k and write results into a shadow vector, swapping after the last row of the iteration.
REQ-029 SHALL give a latency from the accept edge to m_valid high of 1 + iter*DIM*(DIM+1) cycles; 13 cycles for DIM=3, iter=1.
REQ-030 SHALL, when iter=0, go LOAD -> OUT with x_out = x_in and m_valid high 1 cycle after accept.
REQ-031 SHALL, in OUT, hold m_valid and x_out stable until m_ready; on an m_valid && m_ready cycle go to IDLE with s_ready high the next cycle.
REQ-032 SHALL ignore s_valid while busy; the held inputs SHALL be unaffected by input changes during a job.
REQ-033 SHALL keep x_out holding the last result after handshake until the next OUT.

Reset
REQ-034 SHALL, on reset_n low at any time including mid-job, immediately force state IDLE, m_valid=0, busy=0, x_out=0, accumulator=0 and iteration counter=0, and abandon the job.
REQ-035 SHALL drive s_ready=1 on the first rising clk after reset_n returns high.

Verification
REQ-036 SHALL cover: DIM=3, A=I (0x01000000 diagonal), U=0, x_in=(1,2,3), iter=1 -> x_out=(0x01000000, 0x02000000, 0x03000000) with m_valid 13 cycles after accept.
REQ-037 SHALL cover: A rows [0, 0x00800000, 0x000CCCCD], [0x00555555, 0, 0x00555555], [0x000CCCCD, 0x00800000, 0]; x_in=(1,2,3); U=(0x0019999A, 0x00333333, 0x004CCCCD); iter=1 -> x_out approx (0x01400000, 0x01888889, 0x0159999A) within +/-2 LSB.
REQ-038 SHALL cover: A=0.5*I (0x00800000), U=0, x_in=(1,2,3), iter=2 -> (0x00400000, 0x00800000, 0x00C00000) with m_valid after 25 cycles; iter=0 -> x_in echoed after 1 cycle.
REQ-039 SHALL cover: A=64*I (0x40000000), x_in=(4,4,4), U=0 -> 0x7FFFFFFF each with WRAP=0, and 0x00000000 each with WRAP=1.
REQ-040 SHALL cover: m_ready held low 10 cycles in OUT -> m_valid and x_out stable and s_ready=0; s_valid pulsed mid-job -> ignored.
REQ-041 SHALL cover: reset_n low at cycle 6 of a job -> m_valid=0, busy=0 at once; after release, a new job completes correctly.
